// File: rtl/button_toggle_driver.sv
// Push-button conditioner: synchronise, debounce, and emit a toggle pulse
// on short presses or a force_off strobe on long holds.
module button_toggle_driver #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned LONG_CYCLES     = 50000000,
   parameter int unsigned PULSE_CYCLES    = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_n,
   output logic toggle_pulse,
   output logic force_off,
   output logic pressed,
   output logic busy
);

   localparam int unsigned CW = $clog2(LONG_CYCLES) + 1;

   localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] LONG_LAST  = CW'(LONG_CYCLES - 1);
   localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      PRESS_DB,
      HELD,
      RELEASE_DB,
      PULSE,
      LONG_WAIT
   } state_e;

   state_e        state_q, state_d;
   logic [1:0]    sync_q;
   logic          btn_s;
   logic [CW-1:0] db_cnt_q, db_cnt_d;
   logic [CW-1:0] hold_cnt_q, hold_cnt_d;
   logic [CW-1:0] db_inc, hold_inc;
   logic          pressed_q, pressed_d;
   logic          toggle_q, toggle_d;
   logic          force_q, force_d;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == '1) ? v : v + CW'(1);
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], ~btn_n};
      end
   end

   assign btn_s    = sync_q[1];
   assign db_inc   = sat_inc(db_cnt_q);
   assign hold_inc = sat_inc(hold_cnt_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         db_cnt_q   <= '0;
         hold_cnt_q <= '0;
         pressed_q  <= 1'b0;
         toggle_q   <= 1'b0;
         force_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         db_cnt_q   <= db_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         pressed_q  <= pressed_d;
         toggle_q   <= toggle_d;
         force_q    <= force_d;
      end
   end

   // The IDLE->PRESS_DB cycle counts as the first stable sample, so the
   // debounce states leave one increment early to keep press and release
   // latency at 2 sync + DEBOUNCE_CYCLES.
   always_comb begin
      state_d    = state_q;
      db_cnt_d   = db_cnt_q;
      hold_cnt_d = hold_cnt_q;
      pressed_d  = pressed_q;
      toggle_d   = 1'b0;
      force_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (btn_s) begin
               state_d  = PRESS_DB;
               db_cnt_d = '0;
            end
         end
         PRESS_DB: begin
            if (!btn_s) begin
               state_d = IDLE;
            end else if (db_inc == DB_LAST) begin
               state_d    = HELD;
               pressed_d  = 1'b1;
               hold_cnt_d = '0;
            end else begin
               db_cnt_d = db_inc;
            end
         end
         HELD: begin
            hold_cnt_d = hold_inc;
            if (hold_cnt_q == LONG_LAST) begin
               state_d  = LONG_WAIT;
               force_d  = 1'b1;
               db_cnt_d = '0;
            end else if (!btn_s) begin
               state_d  = RELEASE_DB;
               db_cnt_d = '0;
            end
         end
         RELEASE_DB: begin
            if (btn_s) begin
               state_d = HELD;
            end else if (db_inc == DB_LAST) begin
               state_d   = PULSE;
               pressed_d = 1'b0;
               toggle_d  = 1'b1;
               db_cnt_d  = '0;
            end else begin
               db_cnt_d = db_inc;
            end
         end
         PULSE: begin
            if (db_cnt_q == PULSE_LAST) begin
               state_d = IDLE;
            end else begin
               toggle_d = 1'b1;
               db_cnt_d = db_inc;
            end
         end
         LONG_WAIT: begin
            if (btn_s) begin
               db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
               state_d   = IDLE;
               pressed_d = 1'b0;
            end else begin
               db_cnt_d = db_inc;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign toggle_pulse = toggle_q;
   assign force_off    = force_q;
   assign pressed      = pressed_q;
   assign busy         = (state_q != IDLE);

endmodule
